// File: rtl/ocarina_song_controller.sv
// ---------------------------------------------------------------------------
// ocarina_song_controller
//
// Purpose:
//   Front-end sequencer for ocarina song recognition. Each of the four note
//   keys passes through a 2-FF synchroniser and a rising-edge detector.
//   Accepted notes go into a 3-note history, and the history is compared
//   against a fixed five-song table. A single shared FSM with a common timing
//   tick applies an idle timeout to partial sequences and a playback lockout
//   after a successful match.
//
// Parameters:
//   TICK_DIV       clk cycles per timing tick (>= 2)
//   TIMEOUT_TICKS  ticks without a note before a partial sequence is dropped (>= 1)
//   PLAY_TICKS     ticks that busy stays high after a match (>= 1)
//
// Ports:
//   clk          in   system clock
//   resetn       in   asynchronous active-low reset
//   note_keys    in   [3:0] key levels: 0 low, 1 midlow, 2 midhigh, 3 high
//   note_strobe  out  one-cycle pulse per accepted note
//   last_note    out  [1:0] code of the last accepted note
//   note_count   out  [1:0] notes currently held in the history
//   song_valid   out  one-cycle pulse on a song match
//   song_id      out  [2:0] matched song, held until the next match or reset
//   song_fail    out  one-cycle pulse on a failed attempt
//   busy         out  high during the playback lockout
//
// Build option:
//   SONG_MATCH_SLIDING_EN  when defined, the history is a sliding 3-note
//                          window and a miss keeps collecting silently.
//                          When undefined, notes are grouped into disjoint
//                          3-note attempts.
// ---------------------------------------------------------------------------
module ocarina_song_controller #(
    parameter int unsigned TICK_DIV      = 32'd12500000,
    parameter int unsigned TIMEOUT_TICKS = 32'd8,
    parameter int unsigned PLAY_TICKS    = 32'd4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [3:0] note_keys,
    output logic       note_strobe,
    output logic [1:0] last_note,
    output logic [1:0] note_count,
    output logic       song_valid,
    output logic [2:0] song_id,
    output logic       song_fail,
    output logic       busy
);

    localparam int unsigned TICK_W = $clog2(TICK_DIV);
    localparam int unsigned IDLE_W = $clog2(TIMEOUT_TICKS + 32'd1);
    localparam int unsigned PLAY_W = $clog2(PLAY_TICKS + 32'd1);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 32'd1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_TICKS - 32'd1);
    localparam logic [PLAY_W-1:0] PLAY_LAST = PLAY_W'(PLAY_TICKS - 32'd1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_MATCH   = 2'd2,
        S_PLAY    = 2'd3
    } state_t;

    // Song table lookup; notes ordered oldest to newest, returns 0 on miss.
    function automatic logic [2:0] song_lookup(input logic [1:0] n_old,
                                               input logic [1:0] n_mid,
                                               input logic [1:0] n_new);
        logic [5:0] seq;
        seq = {n_old, n_mid, n_new};
        case (seq)
            {2'd2, 2'd3, 2'd1}: song_lookup = 3'd1;  // Zelda
            {2'd3, 2'd2, 2'd1}: song_lookup = 3'd2;  // Epona
            {2'd0, 2'd1, 2'd2}: song_lookup = 3'd3;  // Saria
            {2'd0, 2'd1, 2'd3}: song_lookup = 3'd4;  // Storms
            {2'd3, 2'd1, 2'd2}: song_lookup = 3'd5;  // Wind
            default:            song_lookup = 3'd0;
        endcase
    endfunction

    // Input path registers
    logic [3:0]        sync1_q;
    logic [3:0]        sync2_q;
    logic [3:0]        prev_q;

    // Timing tick
    logic [TICK_W-1:0] tick_cnt_q;
    logic [TICK_W-1:0] tick_cnt_d;
    logic              tick_s;

    // Key event decode
    logic [3:0]        key_evt_s;
    logic              single_evt_s;
    logic              multi_evt_s;
    logic [1:0]        note_code_s;
    logic [2:0]        match_id_s;

    // FSM state, history and registered outputs
    state_t            state_q;
    logic [2:0][1:0]   hist_q;     // [2] oldest, [0] newest
    logic [1:0]        count_q;
    logic [IDLE_W-1:0] idle_cnt_q;
    logic [PLAY_W-1:0] play_cnt_q;
    logic              note_strobe_q;
    logic [1:0]        last_note_q;
    logic              song_valid_q;
    logic [2:0]        song_id_q;
    logic              song_fail_q;
    logic              busy_q;

    // Two-stage synchroniser plus previous-value register for edge detection.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q <= 4'd0;
            sync2_q <= 4'd0;
            prev_q  <= 4'd0;
        end else begin
            sync1_q <= note_keys;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Free-running tick divider next-state and terminal-count decode.
    always_comb begin
        tick_s = (tick_cnt_q == TICK_LAST);
        if (tick_s) begin
            tick_cnt_d = '0;
        end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
        end
    end

    // Tick divider register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

    // Rising-edge events, one-hot classification and note encoding.
    always_comb begin
        key_evt_s    = sync2_q & ~prev_q;
        // A power-of-two test: non-zero with a single bit set.
        single_evt_s = (key_evt_s != 4'd0) && ((key_evt_s & (key_evt_s - 4'd1)) == 4'd0);
        multi_evt_s  = (key_evt_s != 4'd0) && !single_evt_s;
        case (key_evt_s)
            4'b0001: note_code_s = 2'd0;
            4'b0010: note_code_s = 2'd1;
            4'b0100: note_code_s = 2'd2;
            4'b1000: note_code_s = 2'd3;
            default: note_code_s = 2'd0;
        endcase
        match_id_s = song_lookup(hist_q[2], hist_q[1], hist_q[0]);
    end

    // Song sequencer FSM with history and registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= S_IDLE;
            hist_q        <= '0;
            count_q       <= 2'd0;
            idle_cnt_q    <= '0;
            play_cnt_q    <= '0;
            note_strobe_q <= 1'b0;
            last_note_q   <= 2'd0;
            song_valid_q  <= 1'b0;
            song_id_q     <= 3'd0;
            song_fail_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            note_strobe_q <= 1'b0;
            song_valid_q  <= 1'b0;
            song_fail_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (multi_evt_s) begin
                        song_fail_q <= 1'b1;
                        hist_q      <= '0;
                        count_q     <= 2'd0;
                    end else if (single_evt_s) begin
                        hist_q        <= {hist_q[1:0], note_code_s};
                        note_strobe_q <= 1'b1;
                        last_note_q   <= note_code_s;
                        count_q       <= 2'd1;
                        idle_cnt_q    <= '0;
                        state_q       <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (multi_evt_s) begin
                        song_fail_q <= 1'b1;
                        hist_q      <= '0;
                        count_q     <= 2'd0;
                        idle_cnt_q  <= '0;
                        state_q     <= S_IDLE;
                    end else if (single_evt_s) begin
                        hist_q        <= {hist_q[1:0], note_code_s};
                        note_strobe_q <= 1'b1;
                        last_note_q   <= note_code_s;
                        idle_cnt_q    <= '0;
                        // count is 3 only in sliding mode; the window stays full.
                        if (count_q >= 2'd2) begin
                            count_q <= 2'd3;
                            state_q <= S_MATCH;
                        end else begin
                            count_q <= count_q + 2'd1;
                        end
                    end else if (tick_s) begin
                        if (idle_cnt_q == IDLE_LAST) begin
                            hist_q     <= '0;
                            count_q    <= 2'd0;
                            idle_cnt_q <= '0;
                            state_q    <= S_IDLE;
                        end else begin
                            idle_cnt_q <= idle_cnt_q + IDLE_W'(1);
                        end
                    end
                end
                S_MATCH: begin
                    // Key events seen during this cycle are intentionally dropped.
                    idle_cnt_q <= '0;
                    if (match_id_s != 3'd0) begin
                        song_valid_q <= 1'b1;
                        song_id_q    <= match_id_s;
                        busy_q       <= 1'b1;
                        play_cnt_q   <= '0;
                        state_q      <= S_PLAY;
                    end else begin
`ifdef SONG_MATCH_SLIDING_EN
                        state_q <= S_COLLECT;
`else
                        song_fail_q <= 1'b1;
                        hist_q      <= '0;
                        count_q     <= 2'd0;
                        state_q     <= S_IDLE;
`endif
                    end
                end
                S_PLAY: begin
                    // Edge detectors keep running, so a key held through PLAY
                    // cannot produce a late event after the lockout ends.
                    if (tick_s) begin
                        if (play_cnt_q == PLAY_LAST) begin
                            busy_q     <= 1'b0;
                            hist_q     <= '0;
                            count_q    <= 2'd0;
                            play_cnt_q <= '0;
                            state_q    <= S_IDLE;
                        end else begin
                            play_cnt_q <= play_cnt_q + PLAY_W'(1);
                        end
                    end
                end
                default: begin
                    hist_q     <= '0;
                    count_q    <= 2'd0;
                    idle_cnt_q <= '0;
                    play_cnt_q <= '0;
                    busy_q     <= 1'b0;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    assign note_strobe = note_strobe_q;
    assign last_note   = last_note_q;
    assign note_count  = count_q;
    assign song_valid  = song_valid_q;
    assign song_id     = song_id_q;
    assign song_fail   = song_fail_q;
    assign busy        = busy_q;

endmodule
